// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and helpers for the serial magnitude comparator.
//   cmp_state_t   : comparator FSM states (idle, running slices, result pulse)
//   cmp_result_t  : eq/greater pair carried from slice to slice
//   sliceIdxWidth : width of a counter that indexes numSlices slices
// Configuration macro used by the comparator: ALU_CMP_EARLY_EXIT_EN
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        CMP_IDLE = 2'd0,
        CMP_RUN  = 2'd1,
        CMP_DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic eq;
        logic greater;
    } cmp_result_t;

    // A single slice still needs a one-bit index register, so clamp at 1.
    function automatic int sliceIdxWidth(input int numSlices);
        return (numSlices > 1) ? $clog2(numSlices) : 1;
    endfunction

endpackage

// File: rtl/alu_comparator_serial_slice.sv
// -----------------------------------------------------------------------------
// alu_comparator_slice
// Combinational compare of one W-bit slice with cascade inputs from the more
// significant slices. Once a more significant slice has decided the result
// (prev_eq = 0) the cascade state passes through unchanged.
// Ports:
//   a, b          in  W  slice operands
//   prev_eq       in  1  all more significant slices were equal
//   prev_greater  in  1  more significant slices decided a > b
//   invert_msb    in  1  flip the slice MSB on both operands (signed top slice)
//   eq, greater   out 1  cascade state after this slice
// -----------------------------------------------------------------------------
module alu_comparator_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         prev_eq,
    input  logic         prev_greater,
    input  logic         invert_msb,
    output logic         eq,
    output logic         greater
);

    logic [W-1:0] msbMask;
    logic [W-1:0] aAdj;
    logic [W-1:0] bAdj;

    // Flipping the sign bit on both operands turns a two's-complement
    // compare into an unsigned (offset-binary) compare.
    always_comb begin
        msbMask = '0;
        msbMask[W-1] = invert_msb;
        aAdj = a ^ msbMask;
        bAdj = b ^ msbMask;
    end

    always_comb begin
        if (prev_eq) begin
            eq      = (aAdj == bAdj);
            greater = (aAdj > bAdj);
        end else begin
            eq      = 1'b0;
            greater = prev_greater;
        end
    end

endmodule

// File: rtl/alu_comparator_serial.sv
// -----------------------------------------------------------------------------
// alu_comparator_serial
// Multi-cycle magnitude comparator: compares WIDTH-bit operands SLICE bits per
// cycle, most significant slice first, with a start/busy/done handshake.
// Ports:
//   clk          in  1      clock, rising edge
//   rst          in  1      asynchronous active-high reset
//   start        in  1      request a compare (accepted only when idle)
//   signed_mode  in  1      1 = two's-complement, 0 = unsigned (with start)
//   a, b         in  WIDTH  operands (sampled with start)
//   busy         out 1      comparison in progress
//   done         out 1      one-cycle pulse when flags are updated
//   eq, greater, less out 1 result flags, held until the next done
// Configuration: define ALU_CMP_EARLY_EXIT_EN to finish as soon as a slice
// decides the result; otherwise every slice is always processed.
// -----------------------------------------------------------------------------
module alu_comparator_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             greater,
    output logic             less
);

    localparam int NUM_SLICES = WIDTH / SLICE;
    localparam int IW         = sliceIdxWidth(NUM_SLICES);
    localparam logic [IW-1:0] TOP_IDX = IW'(NUM_SLICES - 1);

    if ((WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : gBadConfig
        $error("alu_comparator_serial: WIDTH must be a positive multiple of SLICE");
    end

    cmp_state_t       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    cmp_result_t      run_q, run_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             signed_q, signed_d;
    cmp_result_t      flags_q, flags_d;
    logic             less_q, less_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SLICE-1:0] sliceA;
    logic [SLICE-1:0] sliceB;
    logic             invertMsb;
    cmp_result_t      sliceRes;

    // A single slice comparator is shared across cycles; the current slice
    // is selected by the index, and only the top slice gets the sign flip.
    assign sliceA    = opA_q[int'(idx_q) * SLICE +: SLICE];
    assign sliceB    = opB_q[int'(idx_q) * SLICE +: SLICE];
    assign invertMsb = signed_q && (idx_q == TOP_IDX);

    alu_comparator_slice #(
        .W (SLICE)
    ) uSlice (
        .a            (sliceA),
        .b            (sliceB),
        .prev_eq      (run_q.eq),
        .prev_greater (run_q.greater),
        .invert_msb   (invertMsb),
        .eq           (sliceRes.eq),
        .greater      (sliceRes.greater)
    );

    // Next-state logic. The slice module already freezes the running state
    // once it is decided, so RUN simply takes its output every cycle.
    // Busy and done are computed from the next/current state so that they
    // come straight out of flops.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        run_d    = run_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        signed_d = signed_q;
        flags_d  = flags_q;
        less_d   = less_q;
        done_d   = 1'b0;

        case (state_q)
            CMP_IDLE: begin
                if (start) begin
                    state_d     = CMP_RUN;
                    idx_d       = TOP_IDX;
                    run_d.eq    = 1'b1;
                    run_d.greater = 1'b0;
                    opA_d       = a;
                    opB_d       = b;
                    signed_d    = signed_mode;
                end
            end
            CMP_RUN: begin
                run_d = sliceRes;
                idx_d = idx_q - 1'b1;
`ifdef ALU_CMP_EARLY_EXIT_EN
                if ((idx_q == '0) || !sliceRes.eq) begin
                    state_d = CMP_DONE;
                end
`else
                if (idx_q == '0) begin
                    state_d = CMP_DONE;
                end
`endif
            end
            CMP_DONE: begin
                state_d = CMP_IDLE;
                done_d  = 1'b1;
                flags_d = run_q;
                less_d  = !run_q.eq && !run_q.greater;
            end
            default: begin
                state_d = CMP_IDLE;
            end
        endcase

        busy_d = (state_d == CMP_RUN);
    end

    // State and output registers; reset discards any compare in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= CMP_IDLE;
            idx_q           <= '0;
            run_q.eq        <= 1'b1;
            run_q.greater   <= 1'b0;
            opA_q           <= '0;
            opB_q           <= '0;
            signed_q        <= 1'b0;
            flags_q.eq      <= 1'b1;
            flags_q.greater <= 1'b0;
            less_q          <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            run_q    <= run_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            signed_q <= signed_d;
            flags_q  <= flags_d;
            less_q   <= less_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign eq      = flags_q.eq;
    assign greater = flags_q.greater;
    assign less    = less_q;

endmodule

// File: tb/tb_alu_comparator_serial.sv
// -----------------------------------------------------------------------------
// tb_alu_comparator_serial
// Scoreboard bench: the driver pushes the reference result of every accepted
// compare into a queue; a monitor pops and checks on every done pulse.
// -----------------------------------------------------------------------------
module tb_alu_comparator_serial;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int NUM_SLICES = WIDTH / SLICE;

    typedef struct {
        logic eqExp;
        logic gtExp;
        logic ltExp;
        int   latExp;
        int   acceptCycle;
    } expT;

    logic             clk;
    logic             rst;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             greater;
    logic             less;

    int  checks;
    int  fails;
    int  cycleCnt;
    int  busyCnt;
    logic doneLast;
    expT sb[$];

    alu_comparator_serial #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .greater     (greater),
        .less        (less)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure latency from the accepting edge
    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
    end

    // Global watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (time %0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: plain arithmetic compare; the early-exit latency is the
    // number of slices up to and including the first differing one.
    function automatic expT model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic sm, input int acc);
        expT e;
        logic [WIDTH-1:0] diff;
        int processed;
        e.eqExp = (x == y);
        if (sm) e.gtExp = ($signed(x) > $signed(y));
        else    e.gtExp = (x > y);
        e.ltExp = !e.eqExp && !e.gtExp;
        processed = NUM_SLICES;
`ifdef ALU_CMP_EARLY_EXIT_EN
        diff = x ^ y;
        for (int k = NUM_SLICES - 1; k >= 0; k--) begin
            if (((diff >> (k * SLICE)) & ((1 << SLICE) - 1)) != 0) begin
                processed = NUM_SLICES - k;
                break;
            end
        end
`else
        diff = '0;
`endif
        e.latExp = processed + 1 + int'(diff[0] & 1'b0);
        e.acceptCycle = acc;
        return e;
    endfunction

    // Issue one start; operands are scrambled after acceptance on purpose
    task automatic applyStimulus(input logic [WIDTH-1:0] aIn, input logic [WIDTH-1:0] bIn,
                                 input logic sm, input bit expectAccept);
        @(negedge clk);
        a = aIn;
        b = bIn;
        signed_mode = sm;
        start = 1'b1;
        if (expectAccept) sb.push_back(model(aIn, bIn, sm, cycleCnt + 1));
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        signed_mode = 1'($urandom);
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: checks flags, latency and busy length on every done pulse,
    // and that done never lasts more than one cycle.
    initial begin
        busyCnt = 0;
        doneLast = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busyCnt = 0;
                doneLast = 1'b0;
            end else begin
                if (busy) busyCnt++;
                if (done) begin
                    if (doneLast) begin
                        checks++;
                        fails++;
                        $display("[TB] FAIL done_width: done high 2 cycles, expected 1");
                    end
                    if (sb.size() == 0) begin
                        checks++;
                        fails++;
                        $display("[TB] FAIL unexpected_done: got done pulse, expected none");
                    end else begin
                        expT e;
                        e = sb.pop_front();
                        checkOutput("eq", int'(eq), int'(e.eqExp));
                        checkOutput("greater", int'(greater), int'(e.gtExp));
                        checkOutput("less", int'(less), int'(e.ltExp));
                        checkOutput("latency", cycleCnt - e.acceptCycle, e.latExp);
                        checkOutput("busy_cycles", busyCnt, e.latExp - 1);
                    end
                    busyCnt = 0;
                end
                doneLast = done;
            end
        end
    end

    // Main stimulus sequence
    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        checks = 0;
        fails = 0;
        cycleCnt = 0;
        rst = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);

        $display("[TB] checking reset state");
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_eq", int'(eq), 1);
        checkOutput("reset_greater", int'(greater), 0);
        checkOutput("reset_less", int'(less), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed cases");
        applyStimulus(16'h1234, 16'h1234, 1'b0, 1'b1); waitDrain();
        applyStimulus(16'h8000, 16'h7FFF, 1'b0, 1'b1); waitDrain();
        applyStimulus(16'h8000, 16'h7FFF, 1'b1, 1'b1); waitDrain();
        applyStimulus(16'h0005, 16'h0004, 1'b0, 1'b1); waitDrain();
        applyStimulus(16'hF000, 16'h0000, 1'b0, 1'b1); waitDrain();
        applyStimulus(16'hFFFF, 16'h0001, 1'b1, 1'b1); waitDrain();

        $display("[TB] start while busy is ignored");
        applyStimulus(16'h4321, 16'h4320, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1; a = 16'h0000; b = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        waitDrain();
        repeat (3) @(negedge clk);

        $display("[TB] start in the done cycle is ignored");
        applyStimulus(16'h00A0, 16'h00A1, 1'b0, 1'b1);
        repeat (NUM_SLICES) @(negedge clk);
        start = 1'b1; a = 16'h0000; b = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        waitDrain();
        repeat (NUM_SLICES + 3) @(negedge clk);

        $display("[TB] reset in the middle of a compare");
        applyStimulus(16'h0000, 16'hFFFF, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_done", int'(done), 0);
        checkOutput("midreset_eq", int'(eq), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (NUM_SLICES + 3) @(negedge clk);
        applyStimulus(16'hFFFF, 16'hFFFE, 1'b0, 1'b1); waitDrain();

        $display("[TB] randomized cases");
        for (int i = 0; i < 60; i++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ WIDTH'($urandom_range(1, 15));
                2: rb = ra ^ WIDTH'($urandom_range(1, 255) << 8);
                default: rb = WIDTH'($urandom);
            endcase
            applyStimulus(ra, rb, 1'($urandom), 1'b1);
            waitDrain();
        end

        repeat (NUM_SLICES + 3) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
